// File: rtl/fc_pkg.sv
// Shared definitions for the FC classifier back end: FSM encoding,
// word-count helper, class index width and byte-lane ordering.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fc_state_e;

    localparam int CLASS_IDX_WIDTH = 4;

    // Lane 0 (lowest class index of a word) sits in the most significant byte.
    localparam bit LANE_MSB_FIRST = 1'b1;

    // Number of sram words needed to hold class_num scores.
    function automatic int n_words(input int class_num, input int per_word);
        return (class_num + per_word - 1) / per_word;
    endfunction

    // Bit offset of a lane's LSB inside a packed word.
    function automatic int lane_lsb(input int lane, input int lanes, input int dw);
        return LANE_MSB_FIRST ? (lanes - 1 - lane) * dw : lane * dw;
    endfunction

endpackage

// File: rtl/fc_argmax_lane_cmp.sv
// Folds one packed sram word into a running (max, index) pair.
// Lanes are visited in ascending class order with a strict signed '>'
// so the lowest index wins a tie; masked-off lanes are skipped.
module fc_argmax_lane_cmp
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int IDX_W      = CLASS_IDX_WIDTH
) (
    input  logic [LANES*DATA_WIDTH-1:0] word_i,
    input  logic [IDX_W-1:0]            base_idx_i,
    input  logic [LANES-1:0]            lane_mask_i,
    input  logic signed [DATA_WIDTH-1:0] max_i,
    input  logic [IDX_W-1:0]            idx_i,
    output logic signed [DATA_WIDTH-1:0] max_o,
    output logic [IDX_W-1:0]            idx_o
);

    logic signed [DATA_WIDTH-1:0] score;

    // Sequential compare chain across the lanes of this word.
    always_comb begin
        max_o = max_i;
        idx_o = idx_i;
        score = '0;
        for (int l = 0; l < LANES; l++) begin
            score = $signed(word_i[lane_lsb(l, LANES, DATA_WIDTH) +: DATA_WIDTH]);
            if (lane_mask_i[l] && (score > max_o)) begin
                max_o = score;
                idx_o = base_idx_i + IDX_W'(l);
            end
        end
    end

endmodule

// File: rtl/fc_argmax_unit.sv
// Reads the FC2 class scores back from sram f after fc2_done, finds the
// argmax and offers (class, score) on a valid/ready interface.
// Optional build macro FC_ARGMAX_OVERRUN_EN adds a sticky 'overrun' flag
// that records fc2_done pulses arriving while the unit is busy.
module fc_argmax_unit
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH             = 8,
    parameter int DATA_NUM_PER_SRAM_ADDR = 4,
    parameter int CLASS_NUM              = 10,
    parameter int F_ADDR_WIDTH           = 6
) (
    input  logic                                     clk,
    input  logic                                     srstn,
    input  logic                                     fc2_done,
    output logic [F_ADDR_WIDTH-1:0]                  sram_raddr_f,
    input  logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_rdata_f,
    output logic                                     busy,
    output logic                                     result_valid,
    input  logic                                     result_ready,
    output logic [CLASS_IDX_WIDTH-1:0]               result_class,
    output logic [DATA_WIDTH-1:0]                    result_score
`ifdef FC_ARGMAX_OVERRUN_EN
    ,
    output logic                                     overrun
`endif
);

    localparam int NW    = n_words(CLASS_NUM, DATA_NUM_PER_SRAM_ADDR);
    localparam int LANES = DATA_NUM_PER_SRAM_ADDR;
    localparam logic [F_ADDR_WIDTH-1:0] LAST_ADDR = F_ADDR_WIDTH'(NW - 1);

    fc_state_e state_q, state_d;

    logic [F_ADDR_WIDTH-1:0]       addr_q;
    logic                          rd_vld_q;
    logic [F_ADDR_WIDTH-1:0]       rd_addr_q;
    logic signed [DATA_WIDTH-1:0]  max_q;
    logic [CLASS_IDX_WIDTH-1:0]    idx_q;
    logic signed [DATA_WIDTH-1:0]  res_score_q;
    logic [CLASS_IDX_WIDTH-1:0]    res_class_q;

    logic [LANES-1:0]              lane_mask;
    logic [CLASS_IDX_WIDTH-1:0]    base_idx;
    logic signed [DATA_WIDTH-1:0]  seed_max;
    logic [CLASS_IDX_WIDTH-1:0]    seed_idx;
    logic signed [DATA_WIDTH-1:0]  fold_max;
    logic [CLASS_IDX_WIDTH-1:0]    fold_idx;
    int                            base_int;

    // State register.
    always_ff @(posedge clk) begin
        if (!srstn) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; fc2_done is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fc2_done) state_d = READ;
            READ:    if (addr_q == LAST_ADDR) state_d = DRAIN;
            DRAIN:   state_d = HOLD;
            HOLD:    if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address counter: steps through the words in READ, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!srstn)                                    addr_q <= '0;
        else if (state_q == READ && addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
        else                                           addr_q <= '0;
    end

    // Read data lags its address by one cycle; track which word is arriving.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_vld_q  <= (state_q == READ);
            rd_addr_q <= addr_q;
        end
    end

    // Lane mask, base index and running-max seed for the arriving word.
    // Word 0 is seeded with score 0 itself so an all-minimum run still
    // resolves to class 0.
    always_comb begin
        base_int  = int'(rd_addr_q) * LANES;
        lane_mask = '0;
        for (int l = 0; l < LANES; l++)
            lane_mask[l] = (base_int + l) < CLASS_NUM;
        base_idx = CLASS_IDX_WIDTH'(base_int);
        if (rd_addr_q == '0) begin
            seed_max = $signed(sram_rdata_f[LANES*DATA_WIDTH-1 -: DATA_WIDTH]);
            seed_idx = '0;
        end else begin
            seed_max = max_q;
            seed_idx = idx_q;
        end
    end

    fc_argmax_lane_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .IDX_W      (CLASS_IDX_WIDTH)
    ) u_cmp (
        .word_i      (sram_rdata_f),
        .base_idx_i  (base_idx),
        .lane_mask_i (lane_mask),
        .max_i       (seed_max),
        .idx_i       (seed_idx),
        .max_o       (fold_max),
        .idx_o       (fold_idx)
    );

    // Running max, updated whenever a word arrives.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            max_q <= '0;
            idx_q <= '0;
        end else if (rd_vld_q) begin
            max_q <= fold_max;
            idx_q <= fold_idx;
        end
    end

    // Result registers capture the final fold in DRAIN and hold until the next run ends.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            res_score_q <= '0;
            res_class_q <= '0;
        end else if (state_q == DRAIN) begin
            res_score_q <= fold_max;
            res_class_q <= fold_idx;
        end
    end

`ifdef FC_ARGMAX_OVERRUN_EN
    logic overrun_q;

    // Sticky flag for fc2_done seen while a run is in flight.
    always_ff @(posedge clk) begin
        if (!srstn)                               overrun_q <= 1'b0;
        else if (fc2_done && state_q != IDLE)     overrun_q <= 1'b1;
    end

    assign overrun = overrun_q;
`endif

    assign sram_raddr_f = addr_q;
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == HOLD);
    assign result_class = res_class_q;
    assign result_score = res_score_q;

endmodule
